// File: rtl/rand_arbiter_pkg.sv
// Shared definitions for rand_arbiter: word width, default seed, xorshift step and warm-up FSM states.
// The warm-up states are only used when RAND_ARB_WARMUP_EN is defined.
package rand_arbiter_pkg;

  localparam int RA_W = 32;
  localparam logic [RA_W-1:0] RA_DEFAULT_SEED = 32'hdeadbeef;

  typedef enum logic [0:0] {
    RA_WARMUP = 1'b0,
    RA_RUN    = 1'b1
  } ra_state_e;

  // One xorshift32 advance (13/17/5); a bijection, so a nonzero state never reaches zero.
  function automatic logic [RA_W-1:0] ra_step(input logic [RA_W-1:0] s);
    logic [RA_W-1:0] a;
    logic [RA_W-1:0] b;
    logic [RA_W-1:0] c;
    a = s ^ (s << 5'd13);
    b = a ^ (a >> 5'd17);
    c = b ^ (b << 5'd5);
    return c;
  endfunction

endpackage

// File: rtl/rand_arbiter_rr_pick.sv
// Combinational circular priority picker: first set bit of cand at or above ptr, wrapping at N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  cand,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic          any
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;
  logic          w_take;
  logic          w_found;

  // Walk the candidates starting at ptr; the first hit claims the grant.
  always_comb begin
    onehot  = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    w_take  = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_sum  = {1'b0, ptr} + (PW+1)'(k);
      w_idx  = (w_sum >= (PW+1)'(N)) ? PW'(w_sum - (PW+1)'(N)) : w_sum[PW-1:0];
      w_take = !w_found && cand[w_idx];
      onehot[w_idx] = w_take;
      w_found = w_found | w_take;
    end
  end

  assign any = w_found;

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter handing out one fresh xorshift32 word per clock to N_REQ requesters.
// Optional feature macro RAND_ARB_WARMUP_EN: discard WARMUP generator advances after reset.
module rand_arbiter
  import rand_arbiter_pkg::*;
#(
  parameter int              N_REQ  = 4,
  parameter logic [RA_W-1:0] SEED   = RA_DEFAULT_SEED,
  parameter int              WARMUP = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic [RA_W-1:0]   rand_out,
  output logic [N_REQ-1:0]  pending,
  output logic              ready
);

  localparam int PW = $clog2(N_REQ);

  generate
    if (SEED == '0) begin : g_bad_seed
      $error("rand_arbiter: SEED must be nonzero");
    end
    if ((N_REQ < 2) || (N_REQ > 16)) begin : g_bad_nreq
      $error("rand_arbiter: N_REQ must be in 2..16");
    end
    if (WARMUP < 1) begin : g_bad_warmup
      $error("rand_arbiter: WARMUP must be at least 1");
    end
  endgenerate

  logic [N_REQ-1:0] r_gnt;
  logic [RA_W-1:0]  r_rand;
  logic [N_REQ-1:0] r_pending;
  logic [PW-1:0]    r_ptr;
  logic [RA_W-1:0]  r_state;

  logic [N_REQ-1:0] w_cand;
  logic [N_REQ-1:0] w_win;
  logic             w_any;
  logic [PW-1:0]    w_win_idx;
  logic [PW-1:0]    w_ptr_nxt;
  logic             w_fire;
  logic             w_ready;
  logic             w_warm_adv;

  // A one-cycle req pulse is folded straight into this cycle's candidate set.
  assign w_cand = r_pending | req;

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .cand   (w_cand),
    .ptr    (r_ptr),
    .onehot (w_win),
    .any    (w_any)
  );

  // Encode the one-hot winner back to an index for the pointer update.
  always_comb begin
    w_win_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_win_idx = w_win_idx | (w_win[k] ? PW'(k) : '0);
    end
  end

  assign w_ptr_nxt = (w_win_idx == PW'(N_REQ - 1)) ? '0 : (w_win_idx + PW'(1));
  assign w_fire    = w_ready & w_any;

`ifdef RAND_ARB_WARMUP_EN
  localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  ra_state_e     r_fsm;
  ra_state_e     w_fsm_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  // Warm-up FSM state and cycle counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fsm <= RA_WARMUP;
      r_cnt <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Leave WARMUP once WARMUP generator advances have been discarded.
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_cnt_nxt = r_cnt;
    case (r_fsm)
      RA_WARMUP: begin
        if (r_cnt == CW'(WARMUP - 1)) begin
          w_fsm_nxt = RA_RUN;
          w_cnt_nxt = '0;
        end else begin
          w_fsm_nxt = RA_WARMUP;
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      RA_RUN: begin
        w_fsm_nxt = RA_RUN;
        w_cnt_nxt = '0;
      end
      default: begin
        w_fsm_nxt = RA_WARMUP;
        w_cnt_nxt = '0;
      end
    endcase
  end

  assign w_ready    = (r_fsm == RA_RUN);
  assign w_warm_adv = (r_fsm == RA_WARMUP);
`else
  assign w_ready    = 1'b1;
  assign w_warm_adv = 1'b0;
`endif

  // Grant, word delivery, generator advance and request bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_gnt     <= '0;
      r_rand    <= '0;
      r_pending <= '0;
      r_ptr     <= '0;
      r_state   <= SEED;
    end else if (w_fire) begin
      r_gnt     <= w_win;
      r_rand    <= r_state;
      r_state   <= ra_step(r_state);
      r_ptr     <= w_ptr_nxt;
      r_pending <= w_cand & ~w_win;
    end else begin
      r_gnt     <= '0;
      r_pending <= w_cand;
      if (w_warm_adv) begin
        r_state <= ra_step(r_state);
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign gnt      = r_gnt;
  assign rand_out = r_rand;
  assign pending  = r_pending;
  assign ready    = w_ready;

endmodule
